// File: rtl/conv_tile_sched_pkg.sv
// Shared state encoding and derived-geometry helpers for the conv tile scheduler.
package conv_tile_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_COMPUTE,
    S_DRAIN_ISSUE,
    S_DRAIN,
    S_NEXT,
    S_FINISH
  } state_t;

  function automatic int ofm_size(input int ifm, input int wsz);
    return ifm - wsz + 1;
  endfunction

  function automatic int npix(input int ifm, input int wsz);
    return ofm_size(ifm, wsz) * ofm_size(ifm, wsz);
  endfunction

  // Number of tiles (NPT for pixels, NFG for filters).
  function automatic int num_tiles(input int total, input int sz);
    return (total + sz - 1) / sz;
  endfunction

  function automatic int last_cnt(input int total, input int sz);
    return total - (num_tiles(total, sz) - 1) * sz;
  endfunction

  function automatic int width_of(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/conv_tile_scheduler_tile_index_counter.sv
// Two-level tile walker: pixel tile inner, filter group outer. Base and count
// registers are updated together so they can drive the compute fields directly.
module tile_index_counter
  import conv_tile_sched_pkg::*;
#(
  parameter int NPIX   = 3844,
  parameter int NFILT  = 16,
  parameter int SZ     = 16,
  parameter int PIX_W  = 12,
  parameter int FILT_W = 5,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [PIX_W-1:0]  pix_base,
  output logic [CNT_W-1:0]  pix_cnt,
  output logic [FILT_W-1:0] filt_base,
  output logic [CNT_W-1:0]  filt_cnt,
  output logic              last_pix_tile,
  output logic              last_tile
);

  localparam logic [CNT_W-1:0]  FULL_CNT       = CNT_W'(SZ);
  localparam logic [PIX_W-1:0]  PIX_STEP       = PIX_W'(SZ);
  localparam logic [PIX_W-1:0]  PIX_LAST_BASE  = PIX_W'((num_tiles(NPIX, SZ) - 1) * SZ);
  localparam logic [CNT_W-1:0]  PIX_LAST_CNT   = CNT_W'(last_cnt(NPIX, SZ));
  localparam logic [CNT_W-1:0]  PIX_FIRST_CNT  = (num_tiles(NPIX, SZ) == 1) ? PIX_LAST_CNT : FULL_CNT;
  localparam logic [FILT_W-1:0] FILT_STEP      = FILT_W'(SZ);
  localparam logic [FILT_W-1:0] FILT_LAST_BASE = FILT_W'((num_tiles(NFILT, SZ) - 1) * SZ);
  localparam logic [CNT_W-1:0]  FILT_LAST_CNT  = CNT_W'(last_cnt(NFILT, SZ));
  localparam logic [CNT_W-1:0]  FILT_FIRST_CNT = (num_tiles(NFILT, SZ) == 1) ? FILT_LAST_CNT : FULL_CNT;

  logic [PIX_W-1:0]  pix_next;
  logic [FILT_W-1:0] filt_next;
  logic              last_filt_group;

  assign pix_next        = pix_base + PIX_STEP;
  assign filt_next       = filt_base + FILT_STEP;
  assign last_pix_tile   = (pix_base == PIX_LAST_BASE);
  assign last_filt_group = (filt_base == FILT_LAST_BASE);
  assign last_tile       = last_pix_tile && last_filt_group;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_base  <= '0;
      pix_cnt   <= '0;
      filt_base <= '0;
      filt_cnt  <= '0;
    end else if (clear) begin
      pix_base  <= '0;
      pix_cnt   <= PIX_FIRST_CNT;
      filt_base <= '0;
      filt_cnt  <= FILT_FIRST_CNT;
    end else if (advance) begin
      if (last_pix_tile) begin
        pix_base <= '0;
        pix_cnt  <= PIX_FIRST_CNT;
        if (last_filt_group) begin
          filt_base <= '0;
          filt_cnt  <= FILT_FIRST_CNT;
        end else begin
          filt_base <= filt_next;
          filt_cnt  <= (filt_next == FILT_LAST_BASE) ? FILT_LAST_CNT : FULL_CNT;
        end
      end else begin
        pix_base <= pix_next;
        pix_cnt  <= (pix_next == PIX_LAST_BASE) ? PIX_LAST_CNT : FULL_CNT;
      end
    end
  end

endmodule

// File: rtl/conv_tile_scheduler.sv
// Layer sequencer: issues compute then drain for every tile, filter group outer.
// CONV_TILE_SCHED_OVERLAP_EN overlaps drain of tile N with compute of tile N+1.
module conv_tile_scheduler
  import conv_tile_sched_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int IFM_SIZE      = 64,
  parameter int IFM_CHANNEL   = 3,
  parameter int WEIGHT_SIZE   = 3,
  parameter int WEIGHT_FILTER = 16,
  localparam int NPIX   = npix(IFM_SIZE, WEIGHT_SIZE),
  localparam int K_LEN  = IFM_CHANNEL * WEIGHT_SIZE * WEIGHT_SIZE,
  localparam int PIX_W  = width_of(NPIX),
  localparam int FILT_W = width_of(WEIGHT_FILTER),
  localparam int CNT_W  = width_of(SYSTOLIC_SIZE),
  localparam int KW     = width_of(K_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cmp_start,
  output logic [PIX_W-1:0]  cmp_pix_base,
  output logic [CNT_W-1:0]  cmp_pix_cnt,
  output logic [FILT_W-1:0] cmp_filt_base,
  output logic [CNT_W-1:0]  cmp_filt_cnt,
  output logic [KW-1:0]     cmp_k_len,
  input  logic              cmp_done,
  output logic              drn_start,
  output logic [PIX_W-1:0]  drn_pix_base,
  output logic [CNT_W-1:0]  drn_pix_cnt,
  output logic [FILT_W-1:0] drn_filt_base,
  output logic [CNT_W-1:0]  drn_filt_cnt,
  input  logic              drn_done
);

  state_t state;
  logic   clear, advance, last_tile, pix_wrap_unused;
`ifdef CONV_TILE_SCHED_OVERLAP_EN
  logic   cmp_seen, drn_seen, both_seen;
`endif

  // The counter registers are the cmp_ fields; they move only on clear/advance.
  tile_index_counter #(
    .NPIX(NPIX), .NFILT(WEIGHT_FILTER), .SZ(SYSTOLIC_SIZE),
    .PIX_W(PIX_W), .FILT_W(FILT_W), .CNT_W(CNT_W)
  ) u_idx (
    .clk(clk), .rst(rst), .clear(clear), .advance(advance),
    .pix_base(cmp_pix_base), .pix_cnt(cmp_pix_cnt),
    .filt_base(cmp_filt_base), .filt_cnt(cmp_filt_cnt),
    .last_pix_tile(pix_wrap_unused), .last_tile(last_tile)
  );

  always_comb begin
    clear = (state == S_IDLE) && start && !abort;
`ifdef CONV_TILE_SCHED_OVERLAP_EN
    both_seen = (cmp_seen || cmp_done) && (drn_seen || drn_done);
    advance   = (state == S_COMPUTE) && both_seen && !last_tile && !abort;
`else
    advance   = (state == S_NEXT) && !last_tile && !abort;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      cmp_start     <= 1'b0;
      cmp_k_len     <= '0;
      drn_start     <= 1'b0;
      drn_pix_base  <= '0;
      drn_pix_cnt   <= '0;
      drn_filt_base <= '0;
      drn_filt_cnt  <= '0;
`ifdef CONV_TILE_SCHED_OVERLAP_EN
      cmp_seen      <= 1'b0;
      drn_seen      <= 1'b0;
`endif
    end else begin
      cmp_start <= 1'b0;
      drn_start <= 1'b0;
      done      <= 1'b0;
      cmp_k_len <= KW'(K_LEN);
      if (abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
`ifdef CONV_TILE_SCHED_OVERLAP_EN
        if (cmp_done && !(state == S_COMPUTE && !cmp_seen)) err <= 1'b1;
        if (drn_done && !((state == S_COMPUTE && !drn_seen) || state == S_DRAIN)) err <= 1'b1;
`else
        if (cmp_done && state != S_COMPUTE) err <= 1'b1;
        if (drn_done && state != S_DRAIN) err <= 1'b1;
`endif
        case (state)
          S_IDLE: if (start) begin
            state     <= S_ISSUE;
            busy      <= 1'b1;
            err       <= 1'b0;
            cmp_start <= 1'b1;
`ifdef CONV_TILE_SCHED_OVERLAP_EN
            cmp_seen  <= 1'b0;
            drn_seen  <= 1'b1;
`endif
          end
          S_ISSUE: state <= S_COMPUTE;
`ifdef CONV_TILE_SCHED_OVERLAP_EN
          S_COMPUTE: begin
            // Each completion is held until its partner arrives.
            if (cmp_done) cmp_seen <= 1'b1;
            if (drn_done) drn_seen <= 1'b1;
            if (both_seen) begin
              state         <= S_DRAIN_ISSUE;
              drn_start     <= 1'b1;
              cmp_start     <= !last_tile;
              cmp_seen      <= 1'b0;
              drn_seen      <= 1'b0;
              drn_pix_base  <= cmp_pix_base;
              drn_pix_cnt   <= cmp_pix_cnt;
              drn_filt_base <= cmp_filt_base;
              drn_filt_cnt  <= cmp_filt_cnt;
            end
          end
          S_DRAIN_ISSUE: state <= cmp_start ? S_COMPUTE : S_DRAIN;
`else
          S_COMPUTE: if (cmp_done) begin
            state         <= S_DRAIN_ISSUE;
            drn_start     <= 1'b1;
            drn_pix_base  <= cmp_pix_base;
            drn_pix_cnt   <= cmp_pix_cnt;
            drn_filt_base <= cmp_filt_base;
            drn_filt_cnt  <= cmp_filt_cnt;
          end
          S_DRAIN_ISSUE: state <= S_DRAIN;
`endif
          S_DRAIN: if (drn_done) state <= S_NEXT;
          S_NEXT: if (last_tile) begin
            state <= S_FINISH;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state     <= S_ISSUE;
            cmp_start <= 1'b1;
          end
          S_FINISH: state <= S_IDLE;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
